// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic        if_valid;
   logic [15:0] if_inst;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;

   modport master (
      output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_plus2,
      input  imem_rdata, imem_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_plus2,
      output imem_rdata, imem_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - WISC-F24 fetch stage: PC, imem read port, IF/ID register, redirect/stall/HALT
// Optional performance counters enabled with FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_in,
   input  logic          redirect_valid,
   input  logic [15:0]   redirect_pc,
   fetch_stage_if.master bus,
   output logic          halted,
   output logic [15:0]   perf_fetch_cnt,
   output logic [15:0]   perf_bubble_cnt
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc, pc_nxt;
   logic        load_inst, load_bubble;
   logic        is_halt;

   logic        ifid_valid;
   logic [15:0] ifid_inst, ifid_pc, ifid_pc_plus2;

   assign is_halt = (bus.imem_rdata[15:11] == 5'b00000);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_RUN;
         pc    <= PC_RESET;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Priority: redirect, stall, halted, memory wait, delivery.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      load_inst   = 1'b0;
      load_bubble = 1'b0;
      if (redirect_valid) begin
         pc_nxt      = {redirect_pc[15:1], 1'b0};
         load_bubble = 1'b1;
         state_nxt   = S_RUN;
      end else if (stall_in) begin
         state_nxt = state;
      end else if (state == S_HALTED) begin
         load_bubble = 1'b1;
      end else if (!bus.imem_ready) begin
         load_bubble = 1'b1;
         state_nxt   = S_WAIT;
      end else begin
         load_inst = 1'b1;
         if (is_halt) begin
            state_nxt = S_HALTED;
         end else begin
            pc_nxt    = pc + 16'd2;
            state_nxt = S_RUN;
         end
      end
   end

   // Bubbles keep the old PC fields; only valid and inst change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_valid    <= 1'b0;
         ifid_inst     <= NOP_INST;
         ifid_pc       <= 16'h0000;
         ifid_pc_plus2 <= 16'h0000;
      end else if (load_bubble) begin
         ifid_valid <= 1'b0;
         ifid_inst  <= NOP_INST;
      end else if (load_inst) begin
         ifid_valid    <= 1'b1;
         ifid_inst     <= bus.imem_rdata;
         ifid_pc       <= pc;
         ifid_pc_plus2 <= pc + 16'd2;
      end
   end

   assign bus.imem_req    = (state != S_HALTED);
   assign bus.imem_addr   = pc;
   assign bus.if_valid    = ifid_valid;
   assign bus.if_inst     = ifid_inst;
   assign bus.if_pc       = ifid_pc;
   assign bus.if_pc_plus2 = ifid_pc_plus2;
   assign halted          = (state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt, bubble_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt  <= 16'h0000;
         bubble_cnt <= 16'h0000;
      end else begin
         if (load_inst && fetch_cnt != 16'hFFFF)
            fetch_cnt <= fetch_cnt + 16'd1;
         if (load_bubble && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
      end
   end

   assign perf_fetch_cnt  = fetch_cnt;
   assign perf_bubble_cnt = bubble_cnt;
`else
   assign perf_fetch_cnt  = 16'h0000;
   assign perf_bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a cycle-level behavioural model
module tb_fetch_stage;
   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in, redirect_valid;
   logic [15:0] redirect_pc;
   logic        halted;
   logic [15:0] perf_fetch_cnt, perf_bubble_cnt;

   fetch_stage_if bus ();

   fetch_stage #(.PC_RESET(16'h0000), .NOP_INST(NOP)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_in        (stall_in),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .bus             (bus),
      .halted          (halted),
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [15:0] inst, pc, pc2, addr;
      logic        req, hlt;
      logic [15:0] fcnt, bcnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] mem [0:32767];

   // Architectural view: where fetch is, what decode sees, whether fetch stopped.
   logic [15:0] m_pc, m_inst, m_ifpc;
   logic        m_valid, m_halted;
   int          m_fetch, m_bubble;

   function automatic logic [15:0] sat(input int v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   function void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic step(input logic st, input logic rv, input logic [15:0] rpc, input logic rdy);
      exp_t        e;
      logic [15:0] word;
      @(negedge clk);
      rst            = 1'b0;
      stall_in       = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      bus.imem_ready = rdy;
      bus.imem_rdata = rdy ? mem[bus.imem_addr[15:1]] : 16'($urandom);
      word = mem[m_pc[15:1]];
      if (rv) begin
         m_pc     = rpc & 16'hFFFE;
         m_halted = 1'b0;
         m_valid  = 1'b0;
         m_inst   = NOP;
         m_bubble++;
      end else if (st) begin
         m_bubble = m_bubble;
      end else if (m_halted || !rdy) begin
         m_valid = 1'b0;
         m_inst  = NOP;
         m_bubble++;
      end else begin
         m_valid = 1'b1;
         m_inst  = word;
         m_ifpc  = m_pc;
         m_fetch++;
         if (word[15:11] == 5'd0) m_halted = 1'b1;
         else m_pc = 16'(m_pc + 16'd2);
      end
      e.valid = m_valid;
      e.inst  = m_inst;
      e.pc    = m_ifpc;
      e.pc2   = 16'(m_ifpc + 16'd2);
      e.addr  = m_pc;
      e.req   = !m_halted;
      e.hlt   = m_halted;
`ifdef FETCH_PERF_CNT_EN
      e.fcnt  = sat(m_fetch);
      e.bcnt  = sat(m_bubble);
`else
      e.fcnt  = 16'h0000;
      e.bcnt  = 16'h0000;
`endif
      sb.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("if_valid", bus.if_valid, mon_e.valid);
         chk("if_inst", bus.if_inst, mon_e.inst);
         if (mon_e.valid) begin
            chk("if_pc", bus.if_pc, mon_e.pc);
            chk("if_pc_plus2", bus.if_pc_plus2, mon_e.pc2);
         end
         chk("imem_addr", bus.imem_addr, mon_e.addr);
         chk("imem_req", bus.imem_req, mon_e.req);
         chk("halted", halted, mon_e.hlt);
         chk("perf_fetch_cnt", perf_fetch_cnt, mon_e.fcnt);
         chk("perf_bubble_cnt", perf_bubble_cnt, mon_e.bcnt);
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_if_valid"}, bus.if_valid, 1'b0);
      chk({tag, "_if_inst"}, bus.if_inst, NOP);
      chk({tag, "_if_pc"}, bus.if_pc, 16'h0000);
      chk({tag, "_if_pc_plus2"}, bus.if_pc_plus2, 16'h0000);
      chk({tag, "_halted"}, halted, 1'b0);
      chk({tag, "_imem_addr"}, bus.imem_addr, 16'h0000);
      chk({tag, "_imem_req"}, bus.imem_req, 1'b1);
      chk({tag, "_perf_fetch"}, perf_fetch_cnt, 16'h0000);
      chk({tag, "_perf_bubble"}, perf_bubble_cnt, 16'h0000);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if (w[15:11] == 5'd0) w[15:11] = 5'b00001;
         mem[i] = w;
      end
      mem[0]     = 16'h4000;
      mem[1]     = 16'h4100;
      mem[2]     = 16'h4200;
      mem[16]    = 16'h0000;

      rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
      bus.imem_ready = 1'b0; bus.imem_rdata = 16'h0000;
      m_pc = 16'h0000; m_inst = NOP; m_ifpc = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_fetch = 0; m_bubble = 0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");

      run(3);
      step(1'b0, 1'b1, 16'h0010, 1'b1);
      repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b0);
      run(2);

      step(1'b0, 1'b1, 16'h0000, 1'b1);
      run(3);
      repeat (2) step(1'b1, 1'b0, 16'h0000, 1'b1);
      run(2);

      step(1'b1, 1'b1, 16'h0101, 1'b1);
      run(2);

      step(1'b0, 1'b1, 16'h0020, 1'b1);
      run(4);
      step(1'b1, 1'b0, 16'h0000, 1'b1);
      run(1);
      step(1'b0, 1'b1, 16'h0040, 1'b0);
      run(2);

      step(1'b0, 1'b1, 16'hFFFE, 1'b1);
      run(3);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
              16'($urandom), $urandom_range(0, 9) < 7);
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drain", 16'(sb.size()), 16'h0000);

      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_state("async_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
